// File: rtl/fft_band_pkg.sv
// Shared types and sizing for the FFT band binner and its renderer consumer.
package fft_band_pkg;

    localparam int N_BANDS = 16;
    localparam int BAND_W  = 16;

    typedef logic [N_BANDS-1:0][BAND_W-1:0] band_arr_t;

    typedef enum logic [1:0] {
        S_ACC,
        S_UPDATE,
        S_PUB
    } state_t;

    // Enough headroom for N_BINS/16 full-scale 16-bit magnitudes per band.
    function automatic int acc_width(input int n_bins);
        return BAND_W + $clog2(n_bins / N_BANDS);
    endfunction

endpackage

// File: rtl/fft_band_binner_bin_magnitude.sv
// bin_magnitude: alpha-max-free magnitude estimate (|re| + |im|) / 2.
module bin_magnitude (
    input  logic signed [15:0] re,
    input  logic signed [15:0] im,
    output logic        [15:0] mag
);

    logic [15:0] abs_re;
    logic [15:0] abs_im;
    logic [16:0] sum;

    // -32768 negates to 16'h8000, which read unsigned is the correct 32768.
    assign abs_re = re[15] ? 16'(-re) : 16'(re);
    assign abs_im = im[15] ? 16'(-im) : 16'(im);
    assign sum    = {1'b0, abs_re} + {1'b0, abs_im};
    assign mag    = sum[16:1];

endmodule

// File: rtl/fft_band_binner.sv
// fft_band_binner: sums FFT bin magnitudes into 16 linear bands and publishes
// them with a one-cycle done pulse. Optional peak-decay smoothing is enabled
// by defining FFT_BAND_DECAY_EN.
module fft_band_binner
    import fft_band_pkg::*;
#(
    parameter int N_BINS      = 256,
    parameter int DECAY_SHIFT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bin_valid,
    input  logic [15:0] i_bin_re,
    input  logic [15:0] i_bin_im,
    input  logic        i_bin_last,
    output band_arr_t   o_fft_data,
    output logic        o_fft_done,
    output logic        o_busy,
    output logic        o_frame_err
);

    localparam int ACC_W = acc_width(N_BINS);
    localparam int LOG_N = $clog2(N_BINS);
    localparam int CNT_W = LOG_N + 1;

    // Reject configurations the band indexing cannot handle.
    if (N_BINS < 16 || (N_BINS & (N_BINS - 1)) != 0 ||
        DECAY_SHIFT < 0 || DECAY_SHIFT > 15) begin : g_param_check
        $error("fft_band_binner: unsupported N_BINS or DECAY_SHIFT");
    end

    state_t                          state, state_nx;
    logic [CNT_W-1:0]                bin_cnt;
    logic [N_BANDS-1:0][ACC_W-1:0]   acc;
    band_arr_t                       stage;
    logic [3:0]                      band_ctr;
    logic [15:0]                     mag;
    logic [3:0]                      band_idx;
    logic                            full;
    logic                            accept;
    logic                            last_in;
    logic                            frame_bad;
    logic [15:0]                     sat;
    logic [15:0]                     result;

    bin_magnitude u_mag (
        .re  (i_bin_re),
        .im  (i_bin_im),
        .mag (mag)
    );

    // Top four bits of the in-frame bin index select the band.
    assign band_idx  = bin_cnt[LOG_N-1 -: 4];
    assign full      = bin_cnt[CNT_W-1];
    assign accept    = (state == S_ACC) && i_bin_valid && !full;
    assign last_in   = (state == S_ACC) && i_bin_valid && i_bin_last;
    // Last must land exactly on bin N_BINS-1; short and overrun frames both miss it.
    assign frame_bad = last_in && (bin_cnt != CNT_W'(N_BINS - 1));
    assign o_busy    = (state != S_ACC);

    // Clamp the wide band sum and optionally hold peaks with a geometric decay.
    always_comb begin
        sat    = (|acc[band_ctr][ACC_W-1:BAND_W]) ? 16'hFFFF : acc[band_ctr][BAND_W-1:0];
        result = sat;
`ifdef FFT_BAND_DECAY_EN
        begin
            logic [15:0] prev;
            logic [15:0] decayed;
            prev    = o_fft_data[band_ctr];
            decayed = prev - (prev >> DECAY_SHIFT);
            result  = (sat > decayed) ? sat : decayed;
        end
`endif
    end

    // Next-state: accumulate until last, sweep 16 bands, publish for one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_ACC:    if (last_in) state_nx = S_UPDATE;
            S_UPDATE: if (band_ctr == 4'd15) state_nx = S_PUB;
            S_PUB:    state_nx = S_ACC;
            default:  state_nx = S_ACC;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_ACC;
        else       state <= state_nx;
    end

    // Datapath: accumulate, stage per band while clearing, then publish atomically.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin_cnt     <= '0;
            acc         <= '0;
            stage       <= '0;
            band_ctr    <= '0;
            o_fft_data  <= '0;
            o_fft_done  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_fft_done  <= 1'b0;
            o_frame_err <= frame_bad || ((state == S_UPDATE) && i_bin_valid);
            case (state)
                S_ACC: begin
                    band_ctr <= '0;
                    if (accept) begin
                        acc[band_idx] <= acc[band_idx] + ACC_W'(mag);
                        bin_cnt       <= bin_cnt + CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    stage[band_ctr] <= result;
                    acc[band_ctr]   <= '0;
                    band_ctr        <= band_ctr + 4'd1;
                end
                S_PUB: begin
                    o_fft_data <= stage;
                    o_fft_done <= 1'b1;
                    bin_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fft_band_binner.md
Name: fft_band_binner

Overview:
- Sits directly upstream of the spectrum renderer.
- Consumes the FFT core's complex bin stream, forms an approximate magnitude per bin and sums bins into 16 linear bands.
- Optionally applies peak-decay smoothing to the band sums.
- Publishes the 16x16-bit band array with a one-cycle done pulse, matching the renderer's fft_data/fft_done inputs.

Parameters:
- N_BINS, 256, bins per frame; power of two, at least 16.
- DECAY_SHIFT, 3, decay step is old >> DECAY_SHIFT; used only with the optional feature.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_bin_valid  in  1  bin beat present.
- i_bin_re  in  16  signed real part.
- i_bin_im  in  16  signed imaginary part.
- i_bin_last  in  1  final beat of frame; qualified by i_bin_valid.
- o_fft_data  out  [15:0][15:0]  band magnitudes; index 0 = lowest band.
- o_fft_done  out  1  one-cycle pulse; o_fft_data newly valid.
- o_busy  out  1  high during update; input beats are dropped.
- o_frame_err  out  1  one-cycle pulse flagging a malformed or overrun frame.

Behaviour:
- Clocking and reset: single clock i_clk. Reset is asynchronous, active-high.
- Reset values: o_fft_data all 0; o_fft_done, o_busy, o_frame_err 0; accumulators 0; bin counter 0; state S_ACC.
- Magnitude per beat: |re| + |im| (17 bits, |-32768| = 32768), then >> 1 gives a 16-bit mag.
- Band index = bin_cnt / (N_BINS/16).
- Accumulators are 16 x ACC_W bits, ACC_W = 16 + log2(N_BINS/16); they never overflow.
- bin_cnt counts accepted beats since frame start.

S_ACC (o_busy = 0):
- Valid beat: add mag into acc[band]; bin_cnt++.
- Beat with i_bin_last: included in the sum, then go to S_UPDATE.
- bin_cnt reaching N_BINS without last: further beats ignored. When last arrives, pulse o_frame_err and close the frame normally.
- Last with bin_cnt+1 < N_BINS (short frame): close normally, pulse o_frame_err on the transition cycle. Unvisited bands contribute 0.

S_UPDATE (o_busy = 1, 16 cycles, band counter b = 0..15):
- sat = min(acc[b], 16'hFFFF).
- Write result[b] into a staging register; clear acc[b].
- Any i_bin_valid during S_UPDATE is dropped, with an o_frame_err pulse that cycle.
- After b = 15, go to S_PUB.

S_PUB (1 cycle, o_busy = 1):
- Copy staging to o_fft_data atomically; pulse o_fft_done.
- Reset bin_cnt to 0; go to S_ACC.

Timing and boundaries:
- Latency: last beat at cycle t; o_fft_done and the new o_fft_data both appear at t+17.
- o_fft_data holds between done pulses.
- Back-to-back frames: a beat presented at t+18 is accepted.
- Reset mid-frame or mid-update: all state cleared, no done pulse, o_fft_data returns to 0.

Optional Feature:
- Macro: FFT_BAND_DECAY_EN.
- Defined: result[b] = max(sat, prev[b] - (prev[b] >> DECAY_SHIFT)).
  - prev is the currently published o_fft_data[b].
  - The subtraction never underflows.
- Undefined: result[b] = sat. DECAY_SHIFT is unused.

Decomposition:
- Package fft_band_pkg holds:
  - N_BANDS = 16 and BAND_W = 16;
  - typedef band_arr_t = logic [15:0][15:0];
  - state enum {S_ACC, S_UPDATE, S_PUB};
  - function acc_width(N_BINS).
- One sub-module, bin_magnitude: combinational |re|+|im|>>1. The renderer reuses band_arr_t.

Test Plan:
- Single frame, N_BINS=256, every beat re=100, im=-50: each band = 16*75 = 1200. Done at t+17; o_frame_err never pulses.
- Bin 0 only, re=-32768, im=-32768, other bins 0: mag = 32768, band0 = 32768, bands 1..15 = 0.
- All beats re=im=32767: acc = 16*32767 = 524272 per band, saturates, every band = 0xFFFF.
- Last at beat 100: short frame. o_frame_err pulses once; bands 7..15 = 0. Beat at cycle t+5 dropped with an extra o_frame_err pulse.
- With FFT_BAND_DECAY_EN, DECAY_SHIFT=3:
  - frame A, every band 800; then frame B, all zero;
  - outputs 800, then 700, then 613 on the following zero frame.
  - Without the macro, frame B reads 0.
- Assert i_rst at cycle t+8 during S_UPDATE: no done pulse, outputs 0. The next full frame yields correct sums.
